// File: rtl/udma_i2s_rx_arbiter.sv
// Round-robin arbiter that merges per-channel I2S RX word streams into a single
// registered uDMA RX stream, granting each channel a burst of up to cfg_burst_len_i words.
module udma_i2s_rx_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] in_data_i,
    input  logic [NUM_CHANNELS-1:0]                in_valid_i,
    output logic [NUM_CHANNELS-1:0]                in_ready_o,
    input  logic [NUM_CHANNELS-1:0]                cfg_en_i,
    input  logic [3:0]                             cfg_burst_len_i,
    output logic [DATA_WIDTH-1:0]                  out_data_o,
    output logic [CH_W-1:0]                        out_ch_o,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [NUM_CHANNELS-1:0]                grant_o,
    output logic                                   busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [CH_W-1:0] grant_reg, grant_next;
    logic [CH_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [4:0]      count_reg, count_next;

    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [CH_W-1:0]       out_ch_reg;
    logic                  out_valid_reg;

    logic [NUM_CHANNELS-1:0] req;
    logic                    any_req;
    logic [CH_W-1:0]         sel_idx;
    logic [CH_W-1:0]         cand_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] cand_hit;

    logic            slot_free;
    logic            accept;
    logic            grant_valid;
    logic            grant_en;
    logic [4:0]      max_len;
    logic [4:0]      count_inc;
    logic [CH_W-1:0] grant_wrap;

    assign req       = in_valid_i & cfg_en_i;
    assign any_req   = |req;
    assign slot_free = !out_valid_reg || out_ready_i;

    // Candidate gi is the channel gi positions after rr_ptr, wrapping modulo NUM_CHANNELS.
    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : gen_cand
            logic [CH_W:0] sum;
            assign sum = {1'b0, rr_ptr_reg} + (CH_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (CH_W+1)'(NUM_CHANNELS))
                                ? CH_W'(sum - (CH_W+1)'(NUM_CHANNELS))
                                : CH_W'(sum);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the candidate closest to rr_ptr wins.
    always_comb begin
        sel_idx = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                sel_idx = cand_idx[k];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : gen_grant
            assign grant_o[gi]    = (state_reg == BURST) && (grant_reg == CH_W'(gi));
            assign in_ready_o[gi] = grant_o[gi] && slot_free && cfg_en_i[gi];
        end
    endgenerate

    assign grant_valid = in_valid_i[grant_reg];
    assign grant_en    = cfg_en_i[grant_reg];
    assign accept      = |(in_valid_i & in_ready_o);
    assign max_len     = (cfg_burst_len_i == 4'd0) ? 5'd1 : {1'b0, cfg_burst_len_i};
    assign count_inc   = count_reg + 5'd1;
    assign grant_wrap  = (grant_reg == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_reg + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        count_next  = count_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    grant_next = sel_idx;
                    count_next = '0;
                    state_next = BURST;
                end
            end
            BURST: begin
                // A count already past a shrunk limit still ends on the next accepted word.
                if (!grant_en) begin
                    state_next  = IDLE;
                    rr_ptr_next = grant_wrap;
                end else if (accept) begin
                    count_next = count_inc;
                    if (count_inc >= max_len) begin
                        state_next  = IDLE;
                        rr_ptr_next = grant_wrap;
                    end
                end else if (slot_free && !grant_valid) begin
                    state_next  = IDLE;
                    rr_ptr_next = grant_wrap;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_data_reg  <= in_data_i[grant_reg];
            out_ch_reg    <= grant_reg;
            out_valid_reg <= 1'b1;
        end else if (out_ready_i) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_data_o  = out_data_reg;
    assign out_ch_o    = out_ch_reg;
    assign out_valid_o = out_valid_reg;
    assign busy_o      = (state_reg == BURST) || out_valid_reg;

endmodule

// File: doc/udma_i2s_rx_arbiter.md
UDMA_I2S_RX_ARBITER -- requirements
Module: udma_i2s_rx_arbiter

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of I2S RX channel streams arbitrated.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width of each stream.
REQ-003 SHALL have parameter CH_W, default $clog2(NUM_CHANNELS), width of the channel index.
REQ-004 SHALL have one clock and an asynchronous active-high reset: clk_i  input  1  system clock; rst_i  input  1  async reset, active high.
REQ-005 in_data_i  input  NUM_CHANNELS x DATA_WIDTH  per-channel words from the channel CDC FIFOs.
REQ-006 in_valid_i  input  NUM_CHANNELS  per-channel word available.
REQ-007 in_ready_o  output  NUM_CHANNELS  per-channel word consumed.
REQ-008 cfg_en_i  input  NUM_CHANNELS  channel participates in arbitration.
REQ-009 cfg_burst_len_i  input  4  maximum words per grant; 0 is treated as 1.
REQ-010 out_data_o  output  DATA_WIDTH  registered word to the uDMA RX channel.
REQ-011 out_ch_o  output  CH_W  source channel of out_data_o.
REQ-012 out_valid_o  output  1  out_data_o/out_ch_o valid.
REQ-013 out_ready_i  input  1  uDMA accepts the word.
REQ-014 grant_o  output  NUM_CHANNELS  one-hot current grant; all zero in IDLE.
REQ-015 busy_o  output  1  state is BURST or out_valid_o is high.

Function
REQ-016 FSM SHALL have two states: IDLE and BURST.
REQ-017 In IDLE, if any bit of (in_valid_i & cfg_en_i) is set, the FSM SHALL select the first set bit at or after rr_ptr (wrapping modulo NUM_CHANNELS), register it as grant g, clear burst count, and move to BURST on the next edge.
REQ-018 In IDLE, in_ready_o SHALL be all zero.
REQ-019 Free slot condition: slot_free = !out_valid_o || out_ready_i.
REQ-020 In BURST, in_ready_o[g] SHALL equal slot_free && cfg_en_i[g]; all other bits SHALL be zero; in_ready_o SHALL NOT depend on in_valid_i.
REQ-021 An accepted word (in_valid_i[g] && in_ready_o[g]) SHALL load out_data_o, set out_ch_o = g and out_valid_o = 1 on the next edge; latency from acceptance to out_valid_o is exactly 1 cycle.
REQ-022 While out_valid_o && !out_ready_i, out_data_o and out_ch_o SHALL hold stable.
REQ-023 out_valid_o SHALL clear on out_ready_i when no new word is accepted in the same cycle.
REQ-024 Burst count SHALL increment per accepted word. When the accepted word makes count equal max(cfg_burst_len_i,1), the FSM SHALL go to IDLE.
REQ-025 In BURST, if slot_free && !in_valid_i[g], the grant SHALL end and the FSM SHALL go to IDLE.
REQ-026 In BURST, if !cfg_en_i[g], the grant SHALL end and the FSM SHALL go to IDLE; a word already in the output register SHALL still be delivered.
REQ-027 On every BURST->IDLE transition, rr_ptr SHALL become (g+1) mod NUM_CHANNELS.
REQ-028 The IDLE arbitration cycle SHALL cost one bubble between grants; back-to-back grants to the same channel are permitted when it is the only requester.
REQ-029 cfg_burst_len_i SHALL be sampled every cycle; a change mid-burst applies to the next count comparison. If the count already exceeds the new value, the grant SHALL end after the next accepted word.
REQ-030 The block SHALL never drop or duplicate a word. For each channel, word order on the output SHALL match input order.

Reset
REQ-031 While rst_i is high, state = IDLE, rr_ptr = 0, burst count = 0, and grant register = 0 SHALL hold asynchronously.
REQ-032 While rst_i is high, out_valid_o = 0, out_data_o = 0, out_ch_o = 0, grant_o = 0, in_ready_o = 0 and busy_o = 0 SHALL hold.
REQ-033 Reset asserted mid-burst SHALL discard the word held in the output register. After deassertion, arbitration SHALL restart from channel 0.

Verification
REQ-034 Scenario: single channel. Ch1 enabled, burst 4, streams 0xA0..0xA9, out_ready_i = 1 -> 10 words appear with out_ch_o = 1, in order. A 1-cycle bubble SHALL appear after every 4th word.
REQ-035 Scenario: round robin. All 4 channels valid continuously, burst 2 -> out_ch_o sequence is 0,0,1,1,2,2,3,3,0,0.
REQ-036 Scenario: backpressure. out_ready_i held low 5 cycles with out_valid_o = 1 -> out_data_o stable, in_ready_o all 0. After release, no loss and no duplication.
REQ-037 Scenario: disable mid-burst. cfg_en_i[2] cleared after 1 of 8 words -> the held word is delivered, then the grant moves to ch3 and rr_ptr = 3.
REQ-038 Scenario: burst_len = 0. Ch0 and ch1 valid -> grants alternate one word each: 0,1,0,1.
REQ-039 Scenario: async reset mid-burst. rst_i asserted between edges -> all outputs 0 immediately. First grant after release goes to the lowest-index enabled valid channel.
